// File: rtl/int_alu_pkg.sv
// Shared definitions for the integer ALU: add/sub opcodes and sequencer state encoding.
package int_alu_pkg;

    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;

    // Sequencer states, shared with other multi-cycle ALU units.
    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } alu_seq_state_e;

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module addsub_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] sum;

    // One extra bit captures the carry out of the slice.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        s    = sum[CHUNK-1:0];
        cout = sum[CHUNK];
    end

endmodule

// File: rtl/multicycle_addsub_unit.sv
// Multi-cycle WIDTH-bit add/subtract unit: CHUNK bits per cycle, LSB slice first,
// carry chained through a register, valid/ready on both sides.
module multicycle_addsub_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RESULT,
    output logic             BOUT,
    output logic             OVF,
    output logic             ZERO,
    output logic             NEG
);

    import int_alu_pkg::*;

    localparam int unsigned NSLICE = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    if (WIDTH % CHUNK != 0) begin : gen_width_check
        $fatal(1, "multicycle_addsub_unit: WIDTH must be a multiple of CHUNK");
    end

    alu_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    // Operands shift right one slice per cycle so the active slice is always at bit 0.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtraction
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [CHUNK-1:0] slice_s;
    logic             slice_cout;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res_ins;

    addsub_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Incoming subtrahend is inverted once at accept; the +1 comes from the initial carry.
    // New slice enters the result at the top; earlier slices shift down.
    always_comb begin
        b_eff   = (op_sub == ADDSUB_OP_SUB) ? ~B : B;
        res_ins = WIDTH'(slice_s) << (WIDTH - CHUNK);
    end

    // Next-state, datapath and flag update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        op_d    = op_q;
        res_d   = res_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = b_eff;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    op_d    = op_sub;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_cout;
                res_d   = (res_q >> CHUNK) | res_ins;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SLICE) begin
                    cnt_d   = '0;
                    state_d = StDone;
                    bout_d  = op_q ? ~slice_cout : slice_cout;
                    ovf_d   = (a_msb_q ^ slice_s[CHUNK-1]) & (b_msb_q ^ slice_s[CHUNK-1]);
                    zero_d  = (res_d == '0);
                    neg_d   = slice_s[CHUNK-1];
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            op_q    <= 1'b0;
            res_q   <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            op_q    <= op_d;
            res_q   <= res_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    // Handshake and result outputs come straight from state and registers.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        RESULT    = res_q;
        BOUT      = bout_q;
        OVF       = ovf_q;
        ZERO      = zero_q;
        NEG       = neg_q;
    end

endmodule

// File: tb/tb_multicycle_addsub_unit.sv
// Bench for multicycle_addsub_unit: three instances (CHUNK 4, 16, 1) share the inputs,
// a vector table covers arithmetic and flags, hand sequences cover stall and reset abort.
module tb_multicycle_addsub_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        op_sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_ready;

    logic        in_ready  [3];
    logic        out_valid [3];
    logic [15:0] res       [3];
    logic        bout      [3];
    logic        ovf       [3];
    logic        zero      [3];
    logic        neg       [3];

    int lat [3];
    int exp_lat [3];
    int n_checks;
    int n_fail;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        bout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    vec_t vecs [7];

    multicycle_addsub_unit #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .op_sub(op_sub), .A(A), .B(B), .out_valid(out_valid[0]), .out_ready(out_ready),
        .RESULT(res[0]), .BOUT(bout[0]), .OVF(ovf[0]), .ZERO(zero[0]), .NEG(neg[0])
    );

    multicycle_addsub_unit #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .op_sub(op_sub), .A(A), .B(B), .out_valid(out_valid[1]), .out_ready(out_ready),
        .RESULT(res[1]), .BOUT(bout[1]), .OVF(ovf[1]), .ZERO(zero[1]), .NEG(neg[1])
    );

    multicycle_addsub_unit #(.WIDTH(16), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .op_sub(op_sub), .A(A), .B(B), .out_valid(out_valid[2]), .out_ready(out_ready),
        .RESULT(res[2]), .BOUT(bout[2]), .OVF(ovf[2]), .ZERO(zero[2]), .NEG(neg[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) until every instance shows out_valid, recording each latency.
    task automatic wait_done();
        int  cyc;
        bit  done;
        for (int k = 0; k < 3; k++) lat[k] = -1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
            done = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && lat[k] < 0) lat[k] = cyc;
                if (!out_valid[k]) done = 1'b0;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: out_valid not seen on all instances within 40 cycles");
        end
    endtask

    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b);
        check("in_ready_before_op", 32'(in_ready[0] & in_ready[1] & in_ready[2]), 32'd1);
        op_sub   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Changing the inputs after accept must not disturb the operation.
        A        = ~a;
        B        = ~b;
        op_sub   = ~op;
        wait_done();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] model;
        n_checks   = 0;
        n_fail     = 0;
        exp_lat[0] = 4;
        exp_lat[1] = 1;
        exp_lat[2] = 16;

        //            op    a         b         res       bout  ovf   zero  neg
        vecs[0] = '{1'b1, 16'h0003, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0001, 16'h0007, 16'hFFFA, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        A         = '0;
        B         = '0;
        out_ready = 1'b0;
        #12;
        check("reset_in_ready", 32'(in_ready[0]), 32'd1);
        check("reset_out_valid", 32'(out_valid[0]), 32'd0);
        check("reset_result", 32'(res[0]), 32'd0);
        check("reset_flags", {28'd0, bout[0], ovf[0], zero[0], neg[0]}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b);
            model = vecs[i].op ? (vecs[i].a - vecs[i].b) : (vecs[i].a + vecs[i].b);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("v%0d_d%0d_latency", i, k), 32'(lat[k]), 32'(exp_lat[k]));
                check($sformatf("v%0d_d%0d_result", i, k), 32'(res[k]), 32'(vecs[i].res));
                check($sformatf("v%0d_d%0d_model", i, k), 32'(res[k]), 32'(model));
                check($sformatf("v%0d_d%0d_bout", i, k), 32'(bout[k]), 32'(vecs[i].bout));
                check($sformatf("v%0d_d%0d_ovf", i, k), 32'(ovf[k]), 32'(vecs[i].ovf));
                check($sformatf("v%0d_d%0d_zero", i, k), 32'(zero[k]), 32'(vecs[i].zero));
                check($sformatf("v%0d_d%0d_neg", i, k), 32'(neg[k]), 32'(vecs[i].neg));
            end
            drain();
        end

        // Output stall: 0x00A0-0x0005 = 0x009B held while a new request is pending.
        run_op(1'b1, 16'h00A0, 16'h0005);
        op_sub   = 1'b0;
        A        = 16'h1111;
        B        = 16'h2222;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("stall%0d_out_valid", c), 32'(out_valid[0]), 32'd1);
            check($sformatf("stall%0d_in_ready", c), 32'(in_ready[0]), 32'd0);
            check($sformatf("stall%0d_result", c), 32'(res[0]), 32'h009B);
            check($sformatf("stall%0d_flags", c), {28'd0, bout[0], ovf[0], zero[0], neg[0]},
                  32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_drain_in_ready", 32'(in_ready[0]), 32'd1);
        check("post_drain_out_valid", 32'(out_valid[0]), 32'd0);
        step();
        in_valid = 1'b0;
        check("accept_after_drain", 32'(in_ready[0]), 32'd0);
        wait_done();
        check("stall_next_latency", 32'(lat[0]), 32'd4);
        check("stall_next_result", 32'(res[0]), 32'h3333);
        drain();

        // Reset abort during BUSY cycle 2.
        op_sub   = 1'b1;
        A        = 16'h5555;
        B        = 16'h1111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("abort_pre_in_ready", 32'(in_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid[0]), 32'd0);
        check("abort_in_ready", 32'(in_ready[0]), 32'd1);
        check("abort_result", 32'(res[0]), 32'd0);
        check("abort_result_c1", 32'(res[2]), 32'd0);
        check("abort_flags", {28'd0, bout[0], ovf[0], zero[0], neg[0]}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        run_op(1'b0, 16'h00FF, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("post_reset_d%0d_latency", k), 32'(lat[k]), 32'(exp_lat[k]));
            check($sformatf("post_reset_d%0d_result", k), 32'(res[k]), 32'h0100);
            check($sformatf("post_reset_d%0d_flags", k),
                  {28'd0, bout[k], ovf[k], zero[k], neg[k]}, 32'd0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
